// File: rtl/band_mixer_pkg.sv
// Shared constants, FSM encoding and saturation helper for the three-band mixer.
// Sample and gain words are signed Q8.14.
package band_mixer_pkg;

  localparam int unsigned DECIM = 14;
  localparam int unsigned MAGN  = 8;
  localparam int unsigned N     = DECIM + MAGN + 1;
  localparam int unsigned ACCW  = N + 2;

  localparam logic [N-1:0] GAIN_UNITY = 23'h004000;

  localparam logic signed [ACCW-1:0] SAT_MAX = {{(ACCW-N+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [ACCW-1:0] SAT_MIN = {{(ACCW-N+1){1'b1}}, {(N-1){1'b0}}};

  typedef enum logic [2:0] {
    StIdle,
    StMulB,
    StMulM,
    StMulA,
    StDone
  } state_e;

  typedef struct packed {
    logic         sat;
    logic [N-1:0] data;
  } sat_res_t;

  function automatic sat_res_t clamp(input logic signed [ACCW-1:0] v);
    sat_res_t r;
    if (v > SAT_MAX) begin
      r.sat  = 1'b1;
      r.data = SAT_MAX[N-1:0];
    end else if (v < SAT_MIN) begin
      r.sat  = 1'b1;
      r.data = SAT_MIN[N-1:0];
    end else begin
      r.sat  = 1'b0;
      r.data = v[N-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/band_mixer_mul_q.sv
// Combinational signed N x N multiply, rescaled by an arithmetic shift back to Q8.14
// and narrowed to the accumulator width.
module band_mixer_mul_q
  import band_mixer_pkg::*;
(
  input  logic signed [N-1:0]    a_i,
  input  logic signed [N-1:0]    b_i,
  output logic signed [ACCW-1:0] prod_o
);

  logic signed [2*N-1:0] prod_full;

  assign prod_full = (2*N)'(a_i) * (2*N)'(b_i);
  assign prod_o    = ACCW'(prod_full >>> DECIM);

endmodule

// File: rtl/band_mixer.sv
// Three-band gain mixer: one shared multiplier scales low/mid/high over three cycles,
// then the saturated sum is registered onto out_data with a one-cycle out_valid.
module band_mixer
  import band_mixer_pkg::*;
(
  input  logic         clock,
  input  logic         reset,
  input  logic         sample_valid,
  input  logic [N-1:0] in_b,
  input  logic [N-1:0] in_m,
  input  logic [N-1:0] in_a,
  input  logic         gain_wr,
  input  logic [1:0]   gain_sel,
  input  logic [N-1:0] gain_data,
  output logic [N-1:0] out_data,
  output logic         out_valid,
  output logic         busy,
  output logic         sat,
  output logic         overrun
);

  state_e                  state_q, state_d;
  logic [2:0][N-1:0]       smp_q, smp_d;
  logic [2:0][N-1:0]       gain_q, gain_d;
  logic [2:0][N-1:0]       shadow_q, shadow_d;
  logic signed [ACCW-1:0]  acc_q, acc_d;
  logic [N-1:0]            out_data_q, out_data_d;
  logic                    out_valid_q, out_valid_d;
  logic                    busy_q, busy_d;
  logic                    sat_q, sat_d;
  logic                    overrun_q, overrun_d;

  logic signed [N-1:0]     mul_a, mul_b;
  logic signed [ACCW-1:0]  term, acc_sum;
  sat_res_t                clamp_res;

  band_mixer_mul_q u_mul (
    .a_i    (mul_a),
    .b_i    (mul_b),
    .prod_o (term)
  );

  // Operand select follows the FSM; the shadow copy keeps mid-mix gain writes invisible.
  always_comb begin
    mul_a = smp_q[0];
    mul_b = shadow_q[0];
    case (state_q)
      StMulM: begin
        mul_a = smp_q[1];
        mul_b = shadow_q[1];
      end
      StMulA: begin
        mul_a = smp_q[2];
        mul_b = shadow_q[2];
      end
      default: ;
    endcase
  end

  assign acc_sum   = acc_q + term;
  assign clamp_res = clamp(acc_sum);

  always_comb begin
    state_d     = state_q;
    smp_d       = smp_q;
    gain_d      = gain_q;
    shadow_d    = shadow_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    busy_d      = busy_q;
    sat_d       = 1'b0;
    overrun_d   = overrun_q | (sample_valid & (state_q != StIdle));

    if (gain_wr) begin
      case (gain_sel)
        2'd0:    gain_d[0] = gain_data;
        2'd1:    gain_d[1] = gain_data;
        2'd2:    gain_d[2] = gain_data;
        default: ;
      endcase
    end

    case (state_q)
      StIdle: begin
        if (sample_valid) begin
          smp_d    = {in_a, in_m, in_b};
          shadow_d = gain_q;
          acc_d    = '0;
          busy_d   = 1'b1;
          state_d  = StMulB;
        end
      end
      StMulB: begin
        acc_d   = acc_sum;
        state_d = StMulM;
      end
      StMulM: begin
        acc_d   = acc_sum;
        state_d = StMulA;
      end
      // Final product folds straight into the clamp so out_valid lands in the DONE cycle.
      StMulA: begin
        acc_d       = acc_sum;
        out_data_d  = clamp_res.data;
        sat_d       = clamp_res.sat;
        out_valid_d = 1'b1;
        state_d     = StDone;
      end
      StDone: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      smp_q       <= '0;
      gain_q      <= {3{GAIN_UNITY}};
      shadow_q    <= {3{GAIN_UNITY}};
      acc_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      sat_q       <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      smp_q       <= smp_d;
      gain_q      <= gain_d;
      shadow_q    <= shadow_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      sat_q       <= sat_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign sat       = sat_q;
  assign overrun   = overrun_q;

endmodule
